// File: rtl/accel_pkg.sv
// Shared encodings for the accelerator datapath blocks.
package accel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_select #(
    parameter int numneurons = 4,
    parameter int tagbits    = 2
) (
    input  logic [numneurons-1:0] req,
    input  logic [tagbits-1:0]    rr_ptr,
    output logic                  gnt_valid,
    output logic [tagbits-1:0]    gnt_idx
);

    logic [tagbits-1:0] idx;

    // Scan from the farthest offset down so the nearest request to rr_ptr wins.
    // The index wraps for free because numneurons == 2**tagbits.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = numneurons - 1; k >= 0; k--) begin
            idx = rr_ptr + tagbits'(k);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/spike_arbiter.sv
// Gathers spike pulses over a timestep and serialises them into the fire FIFO,
// one round-robin-selected neuron tag per cycle, stalling on FIFO full.
module spike_arbiter
    import accel_pkg::*;
#(
    parameter int numneurons = 4,
    parameter int tagbits    = 2
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  step_start,
    input  logic                  step_end,
    input  logic [numneurons-1:0] spike,
    input  logic                  fifo_full,
    output logic                  enq,
    output logic [tagbits-1:0]    in_tag,
    output logic                  busy,
    output logic                  step_done,
    output logic [tagbits:0]      spike_count
);

    arb_state_t              state, state_nxt;
    logic [numneurons-1:0]   pending;
    logic [numneurons-1:0]   clr_mask;
    logic [tagbits-1:0]      rr_ptr;
    logic                    gnt_valid;
    logic [tagbits-1:0]      gnt_idx;
    logic                    grant;

    rr_select #(
        .numneurons (numneurons),
        .tagbits    (tagbits)
    ) u_rr_select (
        .req       (pending),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Grant is combinational so the FIFO captures the tag on the same edge
    // that retires the pending bit.
    assign grant     = (state == COLLECT || state == DRAIN) && gnt_valid && !fifo_full;
    assign enq       = grant;
    assign in_tag    = grant ? gnt_idx : '0;
    assign busy      = (state != IDLE);
    assign step_done = (state == DRAIN) && (pending == '0);

    always_comb begin
        clr_mask = '0;
        if (grant) clr_mask[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step_start)       state_nxt = COLLECT;
            COLLECT: if (step_end)         state_nxt = DRAIN;
            DRAIN:   if (pending == '0)    state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state       <= IDLE;
            pending     <= '0;
            rr_ptr      <= '0;
            spike_count <= '0;
        end else begin
            state <= state_nxt;
            // OR-ing spike after the clear lets a same-cycle re-fire survive its grant.
            case (state)
                COLLECT: pending <= (pending & ~clr_mask) | spike;
                DRAIN:   pending <= pending & ~clr_mask;
                default: pending <= '0;
            endcase
            if (grant) rr_ptr <= gnt_idx + tagbits'(1);
            if (state == IDLE && step_start)
                spike_count <= '0;
            else if (grant && spike_count != '1)
                spike_count <= spike_count + {{tagbits{1'b0}}, 1'b1};
        end
    end

endmodule
